// File: rtl/ulisp_uart_pkg.sv
// Shared definitions for the uLisp UART transmitter: FSM states,
// register map and status bit layout.
package ulisp_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // register indices seen on register_index
   localparam logic [11:0] TX_DATA   = 12'd0;
   localparam logic [11:0] TX_STATUS = 12'd1;

   // bit positions inside the status word
   localparam int unsigned BUSY     = 0;
   localparam int unsigned FULL     = 1;
   localparam int unsigned OVERFLOW = 2;

endpackage

// File: rtl/ulisp_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. A push while full
// is accepted only when a pop happens on the same edge.
module ulisp_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // storage array, written at the tail
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ulisp_uart_tx.sv
// uLisp UART transmitter peripheral: 8N1 serial output fed from a small
// transmit store, with a data register (index 0) and status register
// (index 1). Build option UART_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO;
// without it a single holding register is used.
module ulisp_uart_tx
   import ulisp_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] register_index,
   input  logic        register_read,
   input  logic        register_write,
   input  logic [15:0] register_write_value,
   output logic [15:0] register_read_value,
   output logic        txd
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t   state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        overflow;

   logic        push;
   logic        pop;
   logic [7:0]  head;
   logic        st_full;
   logic        st_empty;
   logic        busy;
   logic        bit_end;
   logic        status_read;
   logic        wdata_unused;

   assign wdata_unused = ^register_write_value[15:8];

   assign status_read = register_read && (register_index == TX_STATUS);
   assign push        = register_write && (register_index == TX_DATA) && !reset;
   assign bit_end     = (clk_cnt == BIT_LAST);
   assign pop         = !st_empty && ((state == IDLE) || ((state == STOP) && bit_end));
   assign busy        = !st_empty || (state != IDLE);

`ifdef UART_TX_FIFO_EN
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        count_unused;

   assign count_unused = ^fifo_count;

   ulisp_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (register_write_value[7:0]),
      .dout  (head),
      .full  (st_full),
      .empty (st_empty),
      .count (fifo_count)
   );
`else
   logic        hold_valid;
   logic [7:0]  hold_data;
   logic [31:0] depth_unused;

   assign depth_unused = FIFO_DEPTH;
   assign st_full      = hold_valid;
   assign st_empty     = !hold_valid;
   assign head         = hold_data;

   // single holding register; a push while occupied needs a same-edge pop
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (push && (!hold_valid || pop)) begin
         hold_valid <= 1'b1;
         hold_data  <= register_write_value[7:0];
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   // sticky overflow: a new drop wins over the clearing status read
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (push && st_full && !pop) begin
         overflow <= 1'b1;
      end else if (status_read) begin
         overflow <= 1'b0;
      end
   end

   // status register read path
   always_comb begin
      register_read_value = '0;
      if (status_read) begin
         register_read_value[BUSY]     = busy;
         register_read_value[FULL]     = st_full;
         register_read_value[OVERFLOW] = overflow;
      end
   end

   // frame sequencer; txd is registered from the current state, so the line
   // follows the state by one cycle and every bit keeps its full length
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         txd     <= 1'b1;
      end else begin
         case (state)
            START:   txd <= 1'b0;
            DATA:    txd <= shreg[0];
            default: txd <= 1'b1;
         endcase

         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (pop) begin
                  shreg <= head;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  shreg   <= {1'b0, shreg[7:1]};
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (pop) begin
                     shreg <= head;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ulisp_uart_tx.sv
// Self-checking bench for ulisp_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Honours UART_TX_FIFO_EN: effective storage depth is 8 with it, 1 without.
module tb_ulisp_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
`ifdef UART_TX_FIFO_EN
   localparam int EFF = DEPTH;
`else
   localparam int EFF = 1;
`endif
   localparam int PERIOD = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] register_index = '0;
   logic        register_read = 1'b0;
   logic        register_write = 1'b0;
   logic [15:0] register_write_value = '0;
   logic [15:0] register_read_value;
   logic        txd;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   longint      starts[$];
   bit          mon_en = 1'b0;

   ulisp_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .register_index       (register_index),
      .register_read        (register_read),
      .register_write       (register_write),
      .register_write_value (register_write_value),
      .register_read_value  (register_read_value),
      .txd                  (txd)
   );

   always #(PERIOD/2) clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // one-cycle write, entered and left at a falling edge
   task automatic wr(input logic [11:0] idx, input logic [15:0] val);
      register_index       = idx;
      register_write_value = val;
      register_write       = 1'b1;
      @(negedge clk);
      register_write       = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [11:0] idx, input logic [15:0] exp);
      register_index = idx;
      register_read  = 1'b1;
      #1;
      check_eq(tag, register_read_value, exp);
      @(negedge clk);
      register_read  = 1'b0;
   endtask

   // consecutive writes from idle; the first is popped on the next edge,
   // so EFF+1 are accepted and the rest dropped
   task automatic burst(input int n, input logic [7:0] base, input bit score,
                        output logic [15:0] st_exp);
      int acc;
      int held;
      acc  = (n < EFF + 1) ? n : EFF + 1;
      held = (n - 1 < EFF) ? n - 1 : EFF;
      for (int i = 0; i < n; i++) begin
         if (score && i < acc) exp_q.push_back(8'(base + i));
         wr(12'd0, {8'hC3, 8'(base + i)});
      end
      register_write_value = '0;
      st_exp = {13'b0, (n > EFF + 1), (held == EFF), 1'b1};
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         register_index = 12'd1;
         register_read  = 1'b1;
         #1;
         if (register_read_value[0] == 1'b0) done = 1'b1;
         @(negedge clk);
      end
      register_read = 1'b0;
      check_eq("idle_timeout", done, 1);
      repeat (2 * CPB) @(negedge clk);
      check_eq("frames_left", exp_q.size(), 0);
   endtask

   task automatic check_gaps(input string tag, input int nframes);
      bit ok = 1'b1;
      check_eq({tag, "_nframes"}, starts.size(), nframes);
      for (int i = 1; i < starts.size(); i++)
         if (starts[i] - starts[i-1] != longint'(10 * CPB * PERIOD)) ok = 1'b0;
      check_eq({tag, "_gapless"}, ok, 1);
   endtask

   // serial monitor: decodes each frame, sampling every cycle of every bit
   task automatic decode_frame();
      logic [9:0] bits;
      logic       first;
      bit         stable = 1'b1;
      bit         aborted = 1'b0;
      longint     t0 = $time;
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < CPB; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (!mon_en) aborted = 1'b1;
            if (k == 0) first = txd;
            else if (txd !== first) stable = 1'b0;
         end
         bits[b] = first;
      end
      if (aborted) return;
      starts.push_back(t0);
      if (exp_q.size() == 0) begin
         check_eq("unexpected_frame", {24'b0, bits[8:1]}, 32'h100);
      end else begin
         check_eq("frame_data", bits[8:1], exp_q.pop_front());
         check_eq("frame_shape", {stable, bits[0], bits[9]}, 3'b101);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && txd === 1'b0) decode_frame();
      end
   end

   initial begin
      #(100000 * PERIOD);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] st;
      int          lows;

      // reset, with a write presented during reset that must be discarded
      @(negedge clk);
      wr(12'd0, 16'h0055);
      repeat (2) @(negedge clk);
      check_eq("reset_txd", txd, 1);
      rd_check("reset_status", 12'd1, 16'h0000);
      reset = 1'b0;
      mon_en = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("reset_write_dropped", txd, 1);
      rd_check("post_reset_status", 12'd1, 16'h0000);

      // single 0x41 frame with exact start latency
      starts.delete();
      exp_q.push_back(8'h41);
      wr(12'd0, 16'h0041);
      check_eq("lat_edge1", txd, 1);
      @(negedge clk);
      check_eq("lat_edge2", txd, 1);
      @(negedge clk);
      check_eq("lat_fall", txd, 0);
      wait_idle();
      check_gaps("single", 1);
      rd_check("idle_status", 12'd1, 16'h0000);

      // assorted patterns, upper write bits ignored
      exp_q.push_back(8'hA5); wr(12'd0, 16'h00A5); wait_idle();
      exp_q.push_back(8'h5A); wr(12'd0, 16'hAB5A); wait_idle();
      exp_q.push_back(8'h00); wr(12'd0, 16'hFF00); wait_idle();
      begin
         logic [7:0] r;
         r = 8'($urandom_range(0, 255));
         exp_q.push_back(r); wr(12'd0, {8'h00, r}); wait_idle();
      end

      // nine back-to-back writes
      starts.delete();
      burst(9, 8'h30, 1'b1, st);
      rd_check("burst9_status", 12'd1, st);
      wait_idle();
      check_gaps("burst9", (9 < EFF + 1) ? 9 : EFF + 1);

      // ten writes: overflow sticky until the status read edge
      starts.delete();
      burst(10, 8'h40, 1'b1, st);
      rd_check("burst10_status", 12'd1, st);
      rd_check("burst10_status2", 12'd1, st & 16'h0003);
      wait_idle();
      check_gaps("burst10", (10 < EFF + 1) ? 10 : EFF + 1);

      // three writes
      burst(3, 8'h50, 1'b1, st);
      rd_check("burst3_status", 12'd1, st);
      wait_idle();

      // unmapped indices
      starts.delete();
      wr(12'd5, 16'h0042);
      rd_check("read_idx2", 12'd2, 16'h0000);
      register_index = 12'd1;
      #1;
      check_eq("status_no_strobe", register_read_value, 0);
      repeat (12 * CPB) @(negedge clk);
      check_eq("idx5_no_frame", starts.size(), 0);
      rd_check("idx5_status", 12'd1, 16'h0000);

      // reset in the middle of a frame with bytes queued
      mon_en = 1'b0;
      burst(4, 8'h60, 1'b0, st);
      repeat (12) @(negedge clk);
      check_eq("midframe_active", txd === 1'b0 || txd === 1'b1, 1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midreset_txd", txd, 1);
      rd_check("midreset_status", 12'd1, 16'h0000);
      reset = 1'b0;
      starts.delete();
      mon_en = 1'b1;
      lows = 0;
      for (int i = 0; i < 15 * CPB; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check_eq("after_reset_quiet", lows, 0);
      rd_check("after_reset_status", 12'd1, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
